// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, arbiter FSM states and response flag bit positions
package alu_pkg;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_NOTA  = 3'b101;
  localparam logic [2:0] ALU_PASSA = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 1;
  localparam int FLG_ZERO  = 0;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: per-requester req_valid/ready + op/a/b bus and tagged rsp_valid/ready + id/result/flags bus
interface alu_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [3*NUM_REQ-1:0] req_op;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [3:0]           rsp_result;
  logic [2:0]           rsp_flags;
  modport master(output req_valid, req_op, req_a, req_b, rsp_ready,
                 input req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags);
  modport slave(input req_valid, req_op, req_a, req_b, rsp_ready,
                output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags);
endinterface

// File: rtl/alu_4bit.sv
// alu_4bit: combinational 4-bit ALU; a/b/alu_ctrl in, result/carry_out/overflow/zero out (carry = no-borrow on SUB)
module alu_4bit import alu_pkg::*; (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] alu_ctrl,
  output logic [3:0] result,
  output logic       carry_out,
  output logic       overflow,
  output logic       zero
);
  logic       sub;
  logic       arith;
  logic [3:0] bb;
  logic [4:0] sum;
  always_comb begin
    sub       = alu_ctrl == ALU_SUB;
    arith     = sub || alu_ctrl == ALU_ADD;
    bb        = sub ? ~b : b;
    sum       = {1'b0, a} + {1'b0, bb} + {4'b0, sub};
    result    = arith ? sum[3:0] :
                alu_ctrl == ALU_AND   ? a & b :
                alu_ctrl == ALU_OR    ? a | b :
                alu_ctrl == ALU_XOR   ? a ^ b :
                alu_ctrl == ALU_NOTA  ? ~a :
                alu_ctrl == ALU_PASSA ? a : b;
    carry_out = arith & sum[4];
    overflow  = arith & (a[3] == bb[3]) & (sum[3] != a[3]);
    zero      = result == 4'd0;
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; req/ptr in, one-hot gnt and encoded idx out (first req at or above ptr, wrapping)
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        idx = W'((int'(ptr) + k) % N);
        gnt = N'(1) << idx;
      end
  end
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin share of one ALU; clk/rst_n, bus (slave), alu_a/b/ctrl out, alu_result/carry/ovf/zero in, busy out
module alu_req_arbiter import alu_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_req_arbiter_if.slave bus,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic             alu_zero,
  output logic             busy
);
  state_t             state, state_nx;
  logic [ID_W-1:0]    ptr, gnt_idx, rsp_id;
  logic [NUM_REQ-1:0] gnt;
  logic               rsp_valid, accept;
  logic [3:0]         rsp_result;
  logic [2:0]         rsp_flags;
  rr_arbiter #(.N(NUM_REQ)) u_arb (.req(bus.req_valid), .ptr(ptr), .gnt(gnt), .idx(gnt_idx));
  assign bus.req_ready  = state == IDLE ? gnt : '0;
  assign accept         = |bus.req_ready;
  assign busy           = state != IDLE;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_flags  = rsp_flags;
  always_comb
    state_nx = state == IDLE ? (accept ? EXEC : IDLE) :
               state == EXEC ? RESP :
               bus.rsp_ready ? IDLE : RESP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // rsp_id doubles as the in-flight ID register; it only has to be stable while rsp_valid is high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      ptr        <= '0;
    end else begin
      if (state == IDLE && accept) begin
        alu_ctrl <= bus.req_op[3*gnt_idx +: 3];
        alu_a    <= bus.req_a[4*gnt_idx +: 4];
        alu_b    <= bus.req_b[4*gnt_idx +: 4];
        rsp_id   <= gnt_idx;
      end
      if (state == EXEC) begin
        rsp_result           <= alu_result;
        rsp_flags[FLG_CARRY] <= alu_carry;
        rsp_flags[FLG_OVF]   <= alu_ovf;
        rsp_flags[FLG_ZERO]  <= alu_zero;
        rsp_valid            <= 1'b1;
      end
      if (state == RESP && bus.rsp_ready) begin
        rsp_valid <= 1'b0;
        ptr       <= rsp_id == ID_W'(NUM_REQ - 1) ? '0 : rsp_id + 1'b1;
      end
    end
`ifdef ASSERTIONS
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));
  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    bus.rsp_valid && !bus.rsp_ready |=> $stable({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags}));
  a_ctrl_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(alu_ctrl));
`endif
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: randomized + directed check of alu_req_arbiter with a real alu_4bit against a transaction-level model
module tb_alu_req_arbiter;
  import alu_pkg::*;
  localparam int N = 4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_ctrl;
  logic       alu_carry, alu_ovf, alu_zero, busy;
  int         passed = 0, total = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  alu_req_arbiter_if #(.NUM_REQ(N)) bus();
  alu_req_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
    .busy(busy)
  );
  alu_4bit u_alu (
    .a(alu_a), .b(alu_b), .alu_ctrl(alu_ctrl),
    .result(alu_result), .carry_out(alu_carry), .overflow(alu_ovf), .zero(alu_zero)
  );
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask
  task automatic timeout(string nm);
    total++;
    $display("FAIL %s: timed out at t=%0t", nm, $time);
  endtask
  function automatic logic [6:0] alu_ref(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    int         ua = int'(a), ub = int'(b), sa = int'($signed(a)), sb = int'($signed(b)), s;
    logic [3:0] r;
    logic       c = 1'b0, v = 1'b0;
    case (op)
      ALU_ADD: begin r = 4'(ua + ub); c = ua + ub > 15; s = sa + sb; v = s > 7 || s < -8; end
      ALU_SUB: begin r = 4'(ua - ub); c = ua >= ub; s = sa - sb; v = s > 7 || s < -8; end
      ALU_AND:   r = a & b;
      ALU_OR:    r = a | b;
      ALU_XOR:   r = a ^ b;
      ALU_NOTA:  r = ~a;
      ALU_PASSA: r = a;
      default:   r = b;
    endcase
    return {r, c, v, r == 4'd0};
  endfunction
  function automatic int first_grant(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  // transaction model: one op in flight; response visible from the second cycle after the accept cycle
  int         m_ptr = 0, m_age = 0, m_id = 0;
  bit         m_fl = 1'b0;
  logic [2:0] m_op = '0;
  logic [3:0] m_a = '0, m_b = '0;
  always @(negedge clk) begin
    int         g;
    logic [6:0] e;
    if (!rst_n) begin
      m_ptr = 0; m_age = 0; m_id = 0; m_fl = 1'b0; m_op = '0; m_a = '0; m_b = '0;
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu", {alu_ctrl, alu_a, alu_b}, 0);
      chk("rst_rsp_fields", {bus.rsp_id, bus.rsp_result, bus.rsp_flags}, 0);
    end else begin
      g = m_fl ? -1 : first_grant(bus.req_valid, m_ptr);
      chk("req_ready", bus.req_ready, g < 0 ? 0 : 1 << g);
      chk("busy", busy, m_fl);
      chk("rsp_valid", bus.rsp_valid, m_fl && m_age >= 1);
      chk("alu_in", {alu_ctrl, alu_a, alu_b}, {m_op, m_a, m_b});
      if (m_fl && m_age >= 1) begin
        e = alu_ref(m_op, m_a, m_b);
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_result", bus.rsp_result, e[6:3]);
        chk("rsp_flags", bus.rsp_flags, e[2:0]);
      end
      if (g >= 0) begin
        m_fl = 1'b1; m_age = 0; m_id = g;
        m_op = bus.req_op[3*g +: 3]; m_a = bus.req_a[4*g +: 4]; m_b = bus.req_b[4*g +: 4];
      end else if (m_fl) begin
        if (m_age >= 1 && bus.rsp_ready) begin m_fl = 1'b0; m_ptr = (m_id + 1) % N; end
        else m_age++;
      end
    end
  end
  task automatic set_req(int r, logic [2:0] op, logic [3:0] a, logic [3:0] b);
    bus.req_op[3*r +: 3] = op;
    bus.req_a[4*r +: 4]  = a;
    bus.req_b[4*r +: 4]  = b;
  endtask
  task automatic wait_grant(output int g);
    g = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.req_ready != 0) begin g = $clog2(bus.req_ready); return; end
    end
    timeout("wait_grant");
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) return;
    end
    timeout("wait_rsp");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int g, lat, last;
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b0;
    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    set_req(0, ALU_ADD, 4'h7, 4'h1); bus.req_valid = 4'b0001;
    wait_grant(g); chk("t1_grant", g, 0);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_rsp(lat);
    chk("t1_latency", lat, 2);
    chk("t1_id", bus.rsp_id, 0);
    chk("t1_result", bus.rsp_result, 4'h8);
    chk("t1_flags", bus.rsp_flags, 3'b010);
    @(posedge clk); #1;
    set_req(1, ALU_SUB, 4'h3, 4'h3); bus.req_valid = 4'b0010;
    wait_grant(g); chk("t2_grant", g, 1);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_rsp(lat);
    chk("t2_id", bus.rsp_id, 1);
    chk("t2_result", bus.rsp_result, 4'h0);
    chk("t2_flags", bus.rsp_flags, 3'b101);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int r = 0; r < N; r++) set_req(r, 3'($urandom), 4'($urandom), 4'($urandom));
    bus.req_valid = 4'hF;
    last = 0;
    for (int i = 0; i < 6; i++) begin
      wait_grant(g);
      chk("t3_order", g, exp_order[i]);
      if (i > 0) chk("t3_spacing", cyc - last, 3);
      last = cyc;
      @(posedge clk); #1 set_req(g, 3'($urandom), 4'($urandom), 4'($urandom));
    end
    bus.req_valid = '0;
    repeat (4) @(posedge clk); #1;
    set_req(2, ALU_XOR, 4'hA, 4'h5); bus.req_valid = 4'b0100; bus.rsp_ready = 1'b0;
    wait_grant(g); chk("t4_grant", g, 2);
    @(posedge clk); #1 bus.req_valid = 4'b1011;
    wait_rsp(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", bus.rsp_valid, 1);
      chk("t4_hold_result", {bus.rsp_result, bus.rsp_flags}, {4'hF, 3'b000});
      chk("t4_no_ready", bus.req_ready, 0);
    end
    @(posedge clk); #1 bus.req_valid = '0; bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_done", {bus.rsp_valid, busy}, 0);
    set_req(1, ALU_AND, 4'hC, 4'hA); bus.req_valid = 4'b0010;
    wait_grant(g); chk("t5_grant_req1", g, 1);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_rsp(lat);
    chk("t5_result", bus.rsp_result, 4'h8);
    @(posedge clk); #1 bus.req_valid = 4'hF;
    wait_grant(g); chk("t5_next_round", g, 2);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_rsp(lat);
    @(posedge clk); #1;
    set_req(3, ALU_PASSB, 4'h0, 4'h9); bus.req_valid = 4'b1000;
    wait_grant(g); chk("t6_grant", g, 3);
    @(posedge clk); #1 bus.req_valid = '0;
    chk("t6_exec_alu", {alu_ctrl, alu_b, busy}, {ALU_PASSB, 4'h9, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid_busy", {bus.rsp_valid, busy}, 0);
    chk("t6_rst_alu", {alu_ctrl, alu_a, alu_b}, 0);
    @(posedge clk); #1 rst_n = 1'b1; bus.req_valid = 4'hF;
    wait_grant(g); chk("t6_grant_after_rst", g, 0);
    @(posedge clk); #1 bus.req_valid = '0;
    wait_rsp(lat);
    chk("t6_rsp_id", bus.rsp_id, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      rst_n = $urandom_range(0, 199) != 0;
      bus.req_valid = 4'($urandom);
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      for (int r = 0; r < N; r++) set_req(r, 3'($urandom), 4'($urandom), 4'($urandom));
      @(posedge clk); #1;
    end
    rst_n = 1'b1; bus.req_valid = '0; bus.rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
